// File: rtl/aes_mmio_pkg.sv
// Register map, AXI response codes and FSM state encoding for the AES MMIO driver.
package aes_mmio_pkg;

  localparam logic [15:0] REG_AES_CTL      = 16'h0000;
  localparam logic [15:0] REG_AES_FIFO_IN  = 16'h0004;
  localparam logic [15:0] REG_AES_FIFO_OUT = 16'h0008;
  localparam logic [15:0] REG_AES_CTR      = 16'h0010;
  localparam logic [15:0] REG_AES_KEY      = 16'h0020;

  localparam int CTL_FIFO_OUT_EMPTY = 1;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CFG_KEY = 3'd1;
  localparam logic [2:0] ST_CFG_CTR = 3'd2;
  localparam logic [2:0] ST_BLK_WR  = 3'd3;
  localparam logic [2:0] ST_BLK_RD  = 3'd4;
  localparam logic [2:0] ST_OUT     = 3'd5;

  function automatic logic [15:0] reg_word(input logic [15:0] base, input logic [2:0] idx);
    return base + {11'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/axil_single_xfer.sv
// One AXI4-Lite write or read at a time; AW and W complete independently, then a
// single B (write) or R (read) handshake ends the transfer.
module axil_single_xfer #(
  parameter int ADDR_W = 38
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_is_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_idle,
  output logic              o_done,
  output logic [31:0]       o_rdata,
  output logic [1:0]        o_resp,
  output logic              o_wraddr_valid,
  input  logic              i_wraddr_ready,
  output logic [ADDR_W-1:0] o_wraddr,
  output logic              o_wr_valid,
  input  logic              i_wr_ready,
  output logic [31:0]       o_wr_dat,
  input  logic              i_wrresp_valid,
  output logic              o_wrresp_ready,
  input  logic [1:0]        i_wrresp_dat,
  output logic              o_rdaddr_valid,
  input  logic              i_rdaddr_ready,
  output logic [ADDR_W-1:0] o_rdaddr,
  input  logic              i_rd_valid,
  output logic              o_rd_ready,
  input  logic [31:0]       i_rd_dat,
  input  logic [1:0]        i_rdresp_dat
);

  logic              r_active;
  logic              r_is_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_aw_done;
  logic              r_w_done;
  logic              r_ar_done;
  logic              w_b_hs;
  logic              w_r_hs;

  // Valids/readies decode straight from registers so reset drops them at once.
  assign o_wraddr_valid = r_active & r_is_wr & ~r_aw_done;
  assign o_wr_valid     = r_active & r_is_wr & ~r_w_done;
  assign o_wrresp_ready = r_active & r_is_wr & r_aw_done & r_w_done;
  assign o_rdaddr_valid = r_active & ~r_is_wr & ~r_ar_done;
  assign o_rd_ready     = r_active & ~r_is_wr & r_ar_done;
  assign o_wraddr       = r_addr;
  assign o_rdaddr       = r_addr;
  assign o_wr_dat       = r_wdata;

  assign w_b_hs  = o_wrresp_ready & i_wrresp_valid;
  assign w_r_hs  = o_rd_ready & i_rd_valid;
  assign o_idle  = ~r_active;
  assign o_done  = w_b_hs | w_r_hs;
  assign o_rdata = i_rd_dat;
  assign o_resp  = r_is_wr ? i_wrresp_dat : i_rdresp_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active  <= 1'b0;
      r_is_wr   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_ar_done <= 1'b0;
    end else if (!r_active) begin
      if (i_start) begin
        r_active  <= 1'b1;
        r_is_wr   <= i_is_wr;
        r_addr    <= i_addr;
        r_wdata   <= i_wdata;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_ar_done <= 1'b0;
      end
    end else if (r_is_wr) begin
      if (o_wraddr_valid && i_wraddr_ready) r_aw_done <= 1'b1;
      if (o_wr_valid && i_wr_ready)         r_w_done  <= 1'b1;
      if (w_b_hs)                           r_active  <= 1'b0;
    end else begin
      if (o_rdaddr_valid && i_rdaddr_ready) r_ar_done <= 1'b1;
      if (w_r_hs)                           r_active  <= 1'b0;
    end
  end

endmodule

// File: rtl/aes_axil_driver.sv
// AXI4-Lite initiator sequencing key/counter config and 128-bit blocks through the AES
// MMIO window. Define AES_AXIL_DRIVER_POLL_EN to poll CTL before each FIFO_OUT read.
//
// state      | meaning
// IDLE       | waiting for cfg or block request
// CFG_KEY    | writing 8 key words
// CFG_CTR    | writing 4 counter words
// BLK_WR     | writing 4 plaintext words to FIFO_IN
// BLK_RD     | reading 4 result words from FIFO_OUT (optionally polling CTL)
// OUT        | presenting result until consumed
module aes_axil_driver
  import aes_mmio_pkg::*;
#(
  parameter int                ADDR_W    = 38,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [255:0]      cfg_key,
  input  logic [127:0]      cfg_ctr,
  input  logic              blk_in_valid,
  output logic              blk_in_ready,
  input  logic [127:0]      blk_in,
  output logic              blk_out_valid,
  input  logic              blk_out_ready,
  output logic [127:0]      blk_out,
  output logic              busy,
  output logic              err,
  input  logic              err_clr,
  output logic              wraddr_valid,
  input  logic              wraddr_ready,
  output logic [ADDR_W-1:0] wraddr,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [31:0]       wr_dat,
  input  logic              wrresp_valid,
  output logic              wrresp_ready,
  input  logic [1:0]        wrresp_dat,
  output logic              rdaddr_valid,
  input  logic              rdaddr_ready,
  output logic [ADDR_W-1:0] rdaddr,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [31:0]       rd_dat,
  input  logic [1:0]        rdresp_dat
);

  logic [2:0]   r_state;
  logic [2:0]   r_word_idx;
  logic [255:0] r_key;
  logic [127:0] r_ctr;
  logic [127:0] r_blk;
  logic         r_err;

  logic         w_idle;
  logic         w_done;
  logic [31:0]  w_rdata;
  logic [1:0]   w_resp;
  logic         w_start;
  logic         w_is_wr;
  logic [15:0]  w_off;
  logic [31:0]  w_wdata;
  logic [1:0]   w_idx2;
  logic         w_poll;
  logic         w_xfer_state;

  assign w_idx2 = r_word_idx[1:0];

`ifdef AES_AXIL_DRIVER_POLL_EN
  logic r_poll;

  // Each word starts with a CTL poll; a poll that sees the FIFO non-empty arms the data read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_poll <= 1'b0;
    end else if (r_state == ST_BLK_WR && w_done && r_word_idx == 3'd3) begin
      r_poll <= 1'b1;
    end else if (r_state == ST_BLK_RD && w_done) begin
      r_poll <= r_poll ? w_rdata[CTL_FIFO_OUT_EMPTY] : 1'b1;
    end
  end

  assign w_poll = r_poll;
`else
  assign w_poll = 1'b0;
`endif

  always_comb begin
    w_is_wr = 1'b1;
    w_off   = REG_AES_FIFO_IN;
    w_wdata = r_blk[32*w_idx2 +: 32];
    case (r_state)
      ST_CFG_KEY: begin
        w_off   = reg_word(REG_AES_KEY, r_word_idx);
        w_wdata = r_key[32*r_word_idx +: 32];
      end
      ST_CFG_CTR: begin
        w_off   = reg_word(REG_AES_CTR, r_word_idx);
        w_wdata = r_ctr[32*w_idx2 +: 32];
      end
      ST_BLK_RD: begin
        w_is_wr = 1'b0;
        w_off   = w_poll ? REG_AES_CTL : REG_AES_FIFO_OUT;
        w_wdata = '0;
      end
      default: ;
    endcase
  end

  assign w_xfer_state = (r_state == ST_CFG_KEY) || (r_state == ST_CFG_CTR) ||
                        (r_state == ST_BLK_WR)  || (r_state == ST_BLK_RD);
  assign w_start      = w_idle & w_xfer_state;

  axil_single_xfer #(.ADDR_W(ADDR_W)) u_xfer (
    .clk            (clk),
    .rst            (rst),
    .i_start        (w_start),
    .i_is_wr        (w_is_wr),
    .i_addr         (BASE_ADDR + ADDR_W'(w_off)),
    .i_wdata        (w_wdata),
    .o_idle         (w_idle),
    .o_done         (w_done),
    .o_rdata        (w_rdata),
    .o_resp         (w_resp),
    .o_wraddr_valid (wraddr_valid),
    .i_wraddr_ready (wraddr_ready),
    .o_wraddr       (wraddr),
    .o_wr_valid     (wr_valid),
    .i_wr_ready     (wr_ready),
    .o_wr_dat       (wr_dat),
    .i_wrresp_valid (wrresp_valid),
    .o_wrresp_ready (wrresp_ready),
    .i_wrresp_dat   (wrresp_dat),
    .o_rdaddr_valid (rdaddr_valid),
    .i_rdaddr_ready (rdaddr_ready),
    .o_rdaddr       (rdaddr),
    .i_rd_valid     (rd_valid),
    .o_rd_ready     (rd_ready),
    .i_rd_dat       (rd_dat),
    .i_rdresp_dat   (rdresp_dat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_word_idx <= '0;
      r_key      <= '0;
      r_ctr      <= '0;
      r_blk      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_valid) begin
            r_key      <= cfg_key;
            r_ctr      <= cfg_ctr;
            r_word_idx <= '0;
            r_state    <= ST_CFG_KEY;
          end else if (blk_in_valid) begin
            r_blk      <= blk_in;
            r_word_idx <= '0;
            r_state    <= ST_BLK_WR;
          end
        end
        ST_CFG_KEY: if (w_done) begin
          if (r_word_idx == 3'd7) begin
            r_word_idx <= '0;
            r_state    <= ST_CFG_CTR;
          end else begin
            r_word_idx <= r_word_idx + 3'd1;
          end
        end
        ST_CFG_CTR: if (w_done) begin
          if (r_word_idx == 3'd3) begin
            r_word_idx <= '0;
            r_state    <= ST_IDLE;
          end else begin
            r_word_idx <= r_word_idx + 3'd1;
          end
        end
        ST_BLK_WR: if (w_done) begin
          if (r_word_idx == 3'd3) begin
            r_word_idx <= '0;
            r_state    <= ST_BLK_RD;
          end else begin
            r_word_idx <= r_word_idx + 3'd1;
          end
        end
        ST_BLK_RD: if (w_done && !w_poll) begin
          r_blk[32*w_idx2 +: 32] <= w_rdata;
          if (r_word_idx == 3'd3) begin
            r_word_idx <= '0;
            r_state    <= ST_OUT;
          end else begin
            r_word_idx <= r_word_idx + 3'd1;
          end
        end
        ST_OUT: if (blk_out_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A fresh error response outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_done && w_resp != AXI_RESP_OKAY) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign cfg_ready     = ~rst & (r_state == ST_IDLE) & cfg_valid;
  assign blk_in_ready  = ~rst & (r_state == ST_IDLE) & ~cfg_valid & blk_in_valid;
  assign blk_out_valid = (r_state == ST_OUT);
  assign blk_out       = r_blk;
  assign busy          = (r_state != ST_IDLE);
  assign err           = r_err;

endmodule

// File: tb/tb_aes_axil_driver.sv
// Self-checking bench for aes_axil_driver with a queue-based AXI4-Lite responder model.
module tb_aes_axil_driver;

  localparam int ADDR_W = 38;
  localparam logic [ADDR_W-1:0] A_CTL  = 38'h0;
  localparam logic [ADDR_W-1:0] A_FIN  = 38'h4;
  localparam logic [ADDR_W-1:0] A_FOUT = 38'h8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0, cfg_ready;
  logic [255:0] cfg_key = '0;
  logic [127:0] cfg_ctr = '0;
  logic blk_in_valid = 1'b0, blk_in_ready;
  logic [127:0] blk_in = '0;
  logic blk_out_valid, blk_out_ready = 1'b0;
  logic [127:0] blk_out;
  logic busy, err, err_clr = 1'b0;
  logic wraddr_valid, wraddr_ready = 1'b0;
  logic [ADDR_W-1:0] wraddr, rdaddr;
  logic wr_valid, wr_ready = 1'b0;
  logic [31:0] wr_dat, rd_dat = '0;
  logic wrresp_valid = 1'b0, wrresp_ready;
  logic [1:0] wrresp_dat = '0, rdresp_dat = '0;
  logic rdaddr_valid, rdaddr_ready = 1'b0;
  logic rd_valid = 1'b0, rd_ready;

  aes_axil_driver #(.ADDR_W(ADDR_W), .BASE_ADDR(38'h0)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_key(cfg_key), .cfg_ctr(cfg_ctr),
    .blk_in_valid(blk_in_valid), .blk_in_ready(blk_in_ready), .blk_in(blk_in),
    .blk_out_valid(blk_out_valid), .blk_out_ready(blk_out_ready), .blk_out(blk_out),
    .busy(busy), .err(err), .err_clr(err_clr),
    .wraddr_valid(wraddr_valid), .wraddr_ready(wraddr_ready), .wraddr(wraddr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dat(wr_dat),
    .wrresp_valid(wrresp_valid), .wrresp_ready(wrresp_ready), .wrresp_dat(wrresp_dat),
    .rdaddr_valid(rdaddr_valid), .rdaddr_ready(rdaddr_ready), .rdaddr(rdaddr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_dat(rd_dat), .rdresp_dat(rdresp_dat)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // responder state and transaction logs
  logic [ADDR_W-1:0] aw_q[$], wlog_a[$], rlog_a[$];
  logic [31:0] w_q[$], wlog_d[$], fifo_q[$];
  logic [1:0]  b_q[$];
  logic [31:0] r_q[$];
  int w_stall = 0, w_wait = 0;
  int err_at = -1, n_wr = 0, n_b = 0;
  int ctl_busy_n = 0, ctl_cnt = 0;
  int stab_viol = 0, aw_drop_seen = 0;
  logic prev_w_hold = 1'b0;
  logic [31:0] prev_wdat = '0;

  // Drives responder signals at negedge and predicts the handshakes of the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      aw_q.delete(); w_q.delete(); b_q.delete(); r_q.delete(); fifo_q.delete();
      w_wait = 0; ctl_cnt = 0; prev_w_hold = 1'b0;
      wraddr_ready = 1'b0; wr_ready = 1'b0; wrresp_valid = 1'b0;
      rdaddr_ready = 1'b0; rd_valid = 1'b0;
    end else begin
      wrresp_valid = (b_q.size() > 0);
      wrresp_dat   = (b_q.size() > 0) ? b_q[0] : 2'b00;
      rd_valid     = (r_q.size() > 0);
      rd_dat       = (r_q.size() > 0) ? r_q[0] : 32'h0;
      rdresp_dat   = 2'b00;
      wraddr_ready = 1'b1;
      rdaddr_ready = 1'b1;
      wr_ready     = (w_wait >= w_stall);
      if (wr_valid && prev_w_hold && wr_dat !== prev_wdat) stab_viol++;
      if (wr_valid && !wraddr_valid) aw_drop_seen++;
      prev_w_hold = wr_valid && !wr_ready;
      prev_wdat   = wr_dat;
      if (wraddr_valid && wraddr_ready) aw_q.push_back(wraddr);
      if (wr_valid && wr_ready) begin
        w_q.push_back(wr_dat);
        w_wait = 0;
      end else if (wr_valid) begin
        w_wait++;
      end
      if (aw_q.size() > 0 && w_q.size() > 0) begin
        logic [ADDR_W-1:0] a;
        logic [31:0] d;
        a = aw_q.pop_front();
        d = w_q.pop_front();
        wlog_a.push_back(a);
        wlog_d.push_back(d);
        if (a == A_FIN) fifo_q.push_back(d);
        b_q.push_back((n_wr == err_at) ? 2'b10 : 2'b00);
        n_wr++;
      end
      if (wrresp_valid && wrresp_ready) begin
        void'(b_q.pop_front());
        n_b++;
      end
      if (rdaddr_valid && rdaddr_ready) begin
        rlog_a.push_back(rdaddr);
        if (rdaddr == A_FOUT) begin
          r_q.push_back((fifo_q.size() > 0) ? fifo_q.pop_front() : 32'h0);
          ctl_cnt = 0;
        end else begin
          r_q.push_back((ctl_cnt < ctl_busy_n) ? 32'h2 : 32'h0);
          ctl_cnt++;
        end
      end
      if (rd_valid && rd_ready) void'(r_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wlog_a.delete(); wlog_d.delete(); rlog_a.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk); #1;
    while (busy && n < 3000) begin @(negedge clk); #1; n++; end
    if (n >= 3000) check({tag, "_idle_timeout"}, busy, 0);
  endtask

  task automatic do_cfg(input logic [255:0] key, input logic [127:0] ctr);
    int n = 0, hs = 0;
    clear_logs();
    cfg_key = key; cfg_ctr = ctr; cfg_valid = 1'b1; #1;
    while (!cfg_ready && n < 100) begin @(negedge clk); #1; n++; end
    hs = int'(cfg_ready);
    @(negedge clk); #1;
    hs += int'(cfg_ready);
    cfg_valid = 1'b0;
    check("cfg_ready_pulses", hs, 1);
    wait_idle("cfg");
    check("cfg_num_writes", wlog_a.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < wlog_a.size()) begin
        if (i < 8) begin
          check("cfg_key_addr", wlog_a[i], 38'h20 + 38'(4 * i));
          check("cfg_key_data", wlog_d[i], key[32*i +: 32]);
        end else begin
          check("cfg_ctr_addr", wlog_a[i], 38'h10 + 38'(4 * (i - 8)));
          check("cfg_ctr_data", wlog_d[i], ctr[32*(i-8) +: 32]);
        end
      end
    end
    check("cfg_no_reads", rlog_a.size(), 0);
  endtask

  task automatic send_blk(input logic [127:0] blk);
    int n = 0;
    blk_in = blk; blk_in_valid = 1'b1; #1;
    while (!blk_in_ready && n < 100) begin @(negedge clk); #1; n++; end
    check("blk_in_accepted", blk_in_ready, 1);
    @(negedge clk);
    blk_in_valid = 1'b0;
  endtask

  task automatic do_blk(input logic [127:0] blk, input int out_stall);
    int n = 0, held = 0;
    logic [127:0] first;
    clear_logs();
    send_blk(blk);
    #1;
    while (!blk_out_valid && n < 3000) begin @(negedge clk); #1; n++; end
    check("blk_out_valid_seen", blk_out_valid, 1);
    first = blk_out;
    if (out_stall > 0) begin
      blk_in = ~blk; blk_in_valid = 1'b1;
      for (int k = 0; k < out_stall; k++) begin
        @(negedge clk); #1;
        if (blk_out_valid && blk_out === first && !blk_in_ready) held++;
      end
      blk_in_valid = 1'b0;
      check("out_stall_held", held, out_stall);
    end
    blk_out_ready = 1'b1; #1;
    check("blk_out_data", blk_out, blk);
    @(negedge clk);
    blk_out_ready = 1'b0; #1;
    check("blk_idle_after_out", busy, 0);
    check("blk_num_writes", wlog_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wlog_a.size()) begin
        check("blk_wr_addr", wlog_a[i], A_FIN);
        check("blk_wr_data", wlog_d[i], blk[32*i +: 32]);
      end
    end
    begin
      logic [ADDR_W-1:0] er[$];
      for (int i = 0; i < 4; i++) begin
`ifdef AES_AXIL_DRIVER_POLL_EN
        for (int p = 0; p <= ctl_busy_n; p++) er.push_back(A_CTL);
`endif
        er.push_back(A_FOUT);
      end
      check("blk_num_reads", rlog_a.size(), er.size());
      for (int i = 0; i < er.size(); i++)
        if (i < rlog_a.size()) check("blk_rd_addr", rlog_a[i], er[i]);
    end
  endtask

  initial begin
    logic [255:0] key;
    logic [127:0] ctr, blk;
    int b0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_blk_in_ready", blk_in_ready, 0);
    check("rst_blk_out_valid", blk_out_valid, 0);
    check("rst_blk_out", blk_out, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_axi_valids", {wraddr_valid, wr_valid, wrresp_ready, rdaddr_valid, rd_ready}, 0);
    check("rst_addrs", {wraddr, rdaddr, wr_dat}, 0);
    @(negedge clk);
    rst = 1'b0;

    // directed config and echo block
    for (int i = 0; i < 32; i++) key[8*i +: 8] = 8'(i);
    for (int i = 0; i < 16; i++) ctr[8*i +: 8] = 8'(8'hA0 + (15 - i));
    do_cfg(key, ctr);
    do_blk(128'h33333333_22222222_11111111_00000000, 0);
    check("err_clean", err, 0);

    // randomized configs and blocks, random W stalls
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 8; j++) key[32*j +: 32] = $urandom();
      for (int j = 0; j < 4; j++) ctr[32*j +: 32] = $urandom();
      do_cfg(key, ctr);
    end
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) blk[32*j +: 32] = $urandom();
      w_stall = $urandom_range(0, 2);
      do_blk(blk, 0);
    end

    // W withheld 5 cycles after AW: AW must drop, W data stable, one B per write
    w_stall = 5; stab_viol = 0; aw_drop_seen = 0; b0 = n_b;
    do_blk(128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 0);
    check("stall_aw_dropped", aw_drop_seen > 0, 1);
    check("stall_wdat_stable", stab_viol, 0);
    check("stall_b_count", n_b - b0, 4);
    w_stall = 0;

    // SLVERR on third FIFO_IN write
    err_at = n_wr + 2;
    do_blk(128'h44444444_55555555_66666666_77777777, 0);
    err_at = -1;
    check("err_set", err, 1);
    @(negedge clk); #1;
    check("err_sticky", err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0; #1;
    check("err_cleared", err, 0);

    // output held while consumer stalls
    do_blk(128'h0F0E0D0C_0B0A0908_07060504_03020100, 10);

`ifdef AES_AXIL_DRIVER_POLL_EN
    ctl_busy_n = 2;
    do_blk(128'h99999999_88888888_77777777_66666666, 0);
    ctl_busy_n = 0;
`endif

    // reset during BLK_RD
    begin
      int n = 0;
      send_blk(128'h12345678_12345678_12345678_12345678);
      #1;
      while (!rdaddr_valid && n < 500) begin @(negedge clk); #1; n++; end
      check("rd_phase_reached", rdaddr_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_valids", {wraddr_valid, wr_valid, wrresp_ready, rdaddr_valid, rd_ready,
                               blk_out_valid, busy}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end
    for (int j = 0; j < 4; j++) blk[32*j +: 32] = $urandom();
    do_blk(blk, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
